regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file, the next generation of the processor's architectural register storage. It holds NUM_REGS word-addressed registers of DATA_W bits and serves NUM_RD independent registered read ports plus one byte-enabled write port. Optional write-to-read bypass and a hardwired zero register are included. Registers clear on synchronous reset, so no memory-init file is needed. It sits between decode (read addresses) and writeback (write port) in the single-cycle datapath.

## Interface
- DATA_W, 32: register width in bits; multiple of 8
- NUM_REGS, 32: number of registers; 2..256; need not be a power of two
- NUM_RD, 2: number of read ports; 1..4
- ZERO_REG, 1: 1 = register 0 reads 0 and ignores writes
- BYPASS, 1: 1 = same-cycle write data forwarded to matching reads
- AW (localparam): $clog2(NUM_REGS)
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- we  in  1  write enable
- waddr  in  AW  write register index
- wdata  in  DATA_W  write data
- wbe  in  DATA_W/8  byte-lane write enables; bit k covers wdata[8k+7:8k]
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*AW  read indices; port i at [i*AW +: AW]
- rdata  out  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W]
- rvalid  out  NUM_RD  port i: rdata updated by last edge

## Operation
- Storage is word-addressed. One index selects one DATA_W register. Byte-lane order is little-endian within the word.
- Reset (rst=1 at posedge): all registers, all rdata and all rvalid go to 0. rst overrides we and re in the same cycle; no write occurs.
- Write: when we=1 and rst=0, each lane k with wbe[k]=1 takes the new byte; other lanes hold. we=1 with wbe=0 is a no-op.
- Writes are ignored when waddr ≥ NUM_REGS, or when ZERO_REG=1 and waddr=0.
- Read: when re[i]=1 at a posedge, rdata[i] loads the register at raddr[i] and rvalid[i] goes to 1.
- When re[i]=0 at a posedge, rdata[i] holds its value and rvalid[i] goes to 0.
- Reads return 0 when raddr ≥ NUM_REGS, or when ZERO_REG=1 and raddr=0.
- Same-cycle write and read to the same index:
  - BYPASS=1: rdata gets the merged word, new bytes where wbe is set and old bytes elsewhere.
  - BYPASS=0: rdata gets the pre-write value.
  - Bypass never applies to a suppressed write (zero register or out-of-range index).
- Ports are fully independent. Any number of ports may read the same index in one cycle.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and rdata/rvalid are valid after edge N.
- Write latency is 1 cycle: the write is visible to a read sampled at edge N+1 in both BYPASS modes. With BYPASS=1 it is also visible to a read sampled at edge N.
- Throughput: one write and NUM_RD reads every cycle, with no stalls.
- Reset takes 1 cycle. The cycle after rst deasserts accepts a write and reads normally.
- There is no combinational path from any input to any output.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/NUM_REGS constants;
  - function lane_merge(old, new, be), which returns the byte-masked merge. It is used by both the storage write and the bypass path.
- Sub-module regfile_rd_port, instantiated NUM_RD times via generate. It contains:
  - the index range/zero check;
  - the bypass compare-and-merge;
  - the rdata/rvalid output registers.
- Top level owns the register array, the write decode and the port generate loop.

## Test plan
- Reset: preload registers via writes, then pulse rst with we=1 and re=all-ones. All rdata=0, rvalid=0, and every register reads back 0 afterwards.
- Byte write:
  - Write 0x11223344 to r5 with wbe=1111.
  - Then write 0xAABBCCDD to r5 with wbe=0101.
  - Read r5 → 0x11BB33DD one cycle after re.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to r0 while port0 reads r0 the same cycle → rdata0=0 (no bypass). A later read of r0 → 0.
- Bypass:
  - r7=0x00000000; in one cycle write 0xDEADBEEF with wbe=1100 to r7, with port0 and port1 both reading r7.
  - BYPASS=1: both ports return 0xDEAD0000.
  - BYPASS=0: both return 0x00000000, and a read the next cycle returns 0xDEAD0000.
- Hold/valid:
  - re0=1 reading r3=0x5 on one cycle, then re0=0 the next.
  - rdata0 stays 0x5; rvalid0 goes 1 then 0.
  - Changing raddr0 while re0=0 does not alter rdata0.
- Range: NUM_REGS=20. A write to index 25 leaves every register unchanged; a read of index 25 → 0 with rvalid=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the byte-lane merge helper for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;

    // lane_merge works on a fixed maximum width; callers zero-extend and truncate.
    localparam int LANE_MAX_W  = 256;
    localparam int LANE_MAX_BE = LANE_MAX_W / 8;

    // Byte-masked merge: lanes with be[k]=1 take new_word, others keep old_word.
    function automatic logic [LANE_MAX_W-1:0] lane_merge(
        input logic [LANE_MAX_W-1:0]  old_word,
        input logic [LANE_MAX_W-1:0]  new_word,
        input logic [LANE_MAX_BE-1:0] be
    );
        logic [LANE_MAX_W-1:0] merged;
        merged = old_word;
        for (int unsigned k = 0; k < LANE_MAX_BE; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write port and read ports of the register file, bundled for decode/writeback.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                     we;
    logic [AW-1:0]            waddr;
    logic [DATA_W-1:0]        wdata;
    logic [DATA_W/8-1:0]      wbe;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*AW-1:0]     raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rvalid;

    modport master (
        output we, waddr, wdata, wbe, re, raddr,
        input  rdata, rvalid
    );

    modport slave (
        input  we, waddr, wdata, wbe, re, raddr,
        output rdata, rvalid
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: index check, optional write bypass, rdata/rvalid flops.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    input  logic [DATA_W-1:0]   regs [NUM_REGS],
    input  logic                wr_ok,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid
);

    logic              addr_ok;
    logic              hit;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              rvalid_d, rvalid_q;

    // Select the register value, masking out-of-range and zero-register reads,
    // and forward the same-cycle write when bypass is enabled. wr_ok already
    // excludes suppressed writes, so a hit always targets a readable index.
    always_comb begin
        addr_ok = (32'(raddr) < NUM_REGS) && !((ZERO_REG != 0) && (raddr == '0));
        stored  = '0;
        if (addr_ok) begin
            stored = regs[raddr];
        end
        merged = DATA_W'(lane_merge(LANE_MAX_W'(stored), LANE_MAX_W'(wdata), LANE_MAX_BE'(wbe)));
        hit    = (BYPASS != 0) && wr_ok && (waddr == raddr);
        rd_val = hit ? merged : stored;
    end

    // Load on re, otherwise hold the last data; rvalid mirrors re of the last edge.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = re;
        if (re) begin
            rdata_d = rd_val;
        end
    end

    // Output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Drive ports straight from the flops.
    always_comb begin
        rdata  = rdata_q;
        rvalid = rvalid_q;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: storage array, byte-enabled write decode,
// and NUM_RD independent registered read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [DATA_W-1:0]        regs_d [NUM_REGS];
    logic                     wr_ok;
    logic [NUM_RD*DATA_W-1:0] rdata_all;
    logic [NUM_RD-1:0]        rvalid_all;

    // Write qualification: drop out-of-range indices and the hardwired zero register.
    always_comb begin
        wr_ok = bus.we && (32'(bus.waddr) < NUM_REGS)
                && !((ZERO_REG != 0) && (bus.waddr == '0));
    end

    // Next register contents: merge enabled byte lanes into the addressed word.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[bus.waddr] = DATA_W'(lane_merge(LANE_MAX_W'(regs_q[bus.waddr]),
                                                   LANE_MAX_W'(bus.wdata),
                                                   LANE_MAX_BE'(bus.wbe)));
        end
    end

    // Register array with synchronous clear; reset takes priority over writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .clk    (clk),
            .rst    (rst),
            .re     (bus.re[i]),
            .raddr  (bus.raddr[i*AW +: AW]),
            .regs   (regs_q),
            .wr_ok  (wr_ok),
            .waddr  (bus.waddr),
            .wdata  (bus.wdata),
            .wbe    (bus.wbe),
            .rdata  (rdata_all[i*DATA_W +: DATA_W]),
            .rvalid (rvalid_all[i])
        );
    end

    // Present the per-port flops on the bus.
    always_comb begin
        bus.rdata  = rdata_all;
        bus.rvalid = rvalid_all;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two register files (BYPASS=1 and BYPASS=0, 20 registers,
// zero register on) driven with identical directed vectors.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .NUM_REGS(20), .NUM_RD(2)) ia ();
    regfile_mp_if #(.DATA_W(32), .NUM_REGS(20), .NUM_RD(2)) ib ();

    regfile_mp #(.DATA_W(32), .NUM_REGS(20), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk (clk), .rst (rst), .bus (ia)
    );
    regfile_mp #(.DATA_W(32), .NUM_REGS(20), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk (clk), .rst (rst), .bus (ib)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected read data per (dut, port): index = dut*2 + port.
    logic [31:0] q0[$], q1[$], q2[$], q3[$];
    logic [31:0] hold_exp [4] = '{default: '0};
    logic        rst_s = 1'b0;
    logic        started = 1'b0;

    task automatic push_exp(input int idx, input logic [31:0] v);
        case (idx)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int idx, output logic ok, output logic [31:0] v);
        ok = 1'b0;
        v  = '0;
        case (idx)
            0: if (q0.size() > 0) begin ok = 1'b1; v = q0.pop_front(); end
            1: if (q1.size() > 0) begin ok = 1'b1; v = q1.pop_front(); end
            2: if (q2.size() > 0) begin ok = 1'b1; v = q2.pop_front(); end
            default: if (q3.size() > 0) begin ok = 1'b1; v = q3.pop_front(); end
        endcase
    endtask

    function automatic int q_size(input int idx);
        case (idx)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    // One cycle of stimulus on both DUTs; expected read data is queued per port.
    task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [1:0] rre, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [31:0] ea0, input logic [31:0] ea1,
                         input logic [31:0] eb0, input logic [31:0] eb1);
        rst      = r;
        ia.we    = w;  ib.we    = w;
        ia.waddr = wa; ib.waddr = wa;
        ia.wdata = wd; ib.wdata = wd;
        ia.wbe   = be; ib.wbe   = be;
        ia.re    = rre; ib.re   = rre;
        ia.raddr = {ra1, ra0}; ib.raddr = {ra1, ra0};
        if (!r) begin
            if (rre[0]) begin push_exp(0, ea0); push_exp(2, eb0); end
            if (rre[1]) begin push_exp(1, ea1); push_exp(3, eb1); end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] final_reg(input int i);
        case (i)
            3: return 32'h0000_0005;
            5: return 32'h11BB_33DD;
            7: return 32'hDEAD_0000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_dut(input int d, input logic [63:0] rd_all, input logic [1:0] rv_all,
                             input logic in_rst);
        for (int p = 0; p < 2; p++) begin
            logic [31:0] got;
            logic [31:0] exp;
            logic        ok;
            int          idx;
            idx = d * 2 + p;
            got = rd_all[p*32 +: 32];
            if (in_rst) begin
                n_cmp++;
                if (rv_all[p] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_rvalid dut%0d port%0d: got %b expected 0", d, p, rv_all[p]);
                end
                n_cmp++;
                if (got !== 32'h0) begin
                    n_bad++;
                    $display("FAIL reset_rdata dut%0d port%0d: got %h expected 00000000", d, p, got);
                end
                hold_exp[idx] = '0;
            end else if (rv_all[p] === 1'b1) begin
                pop_exp(idx, ok, exp);
                n_cmp++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL spurious_rvalid dut%0d port%0d: got rvalid=1 expected no read pending", d, p);
                end else begin
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL rdata dut%0d port%0d: got %h expected %h", d, p, got, exp);
                    end
                    hold_exp[idx] = exp;
                end
            end else begin
                n_cmp++;
                if (got !== hold_exp[idx]) begin
                    n_bad++;
                    $display("FAIL hold dut%0d port%0d: got %h expected %h", d, p, got, hold_exp[idx]);
                end
            end
        end
    endtask

    // Record whether the edge just taken was a reset edge.
    always @(posedge clk) begin
        rst_s   = rst;
        started = 1'b1;
    end

    // Monitor: checks outputs half a cycle after every edge.
    always @(negedge clk) begin
        if (started) begin
            check_dut(0, ia.rdata, ia.rvalid, rst_s);
            check_dut(1, ib.rdata, ib.rvalid, rst_s);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        //     rst we wa  wdata         be     re     ra0 ra1  ea0           ea1           eb0           eb1
        drive(1, 0, 0,  32'h0,        4'h0, 2'b00, 0,  0,  0, 0, 0, 0);
        // preload then read back
        drive(0, 1, 5,  32'h11223344, 4'hF, 2'b00, 0,  0,  0, 0, 0, 0);
        drive(0, 1, 3,  32'h00000005, 4'hF, 2'b00, 0,  0,  0, 0, 0, 0);
        drive(0, 1, 7,  32'h12345678, 4'hF, 2'b00, 0,  0,  0, 0, 0, 0);
        drive(0, 1, 19, 32'hCAFEF00D, 4'hF, 2'b11, 5,  3,
              32'h11223344, 32'h5, 32'h11223344, 32'h5);
        // reset overrides write and reads
        drive(1, 1, 5,  32'hFFFFFFFF, 4'hF, 2'b11, 5,  7,  0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 32'h0, 4'h0, 2'b11, 5'(2*i), 5'(2*i+1), 0, 0, 0, 0);
        end
        // byte-lane write; port1 sees bypassed merge on dut_a, old word on dut_b
        drive(0, 1, 5,  32'h11223344, 4'hF, 2'b00, 0,  0,  0, 0, 0, 0);
        drive(0, 1, 5,  32'hAABBCCDD, 4'h5, 2'b10, 0,  5,
              0, 32'h11BB33DD, 0, 32'h11223344);
        drive(0, 0, 0,  32'h0,        4'h0, 2'b11, 5,  5,
              32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);
        // zero register: write ignored, no bypass
        drive(0, 1, 0,  32'hFFFFFFFF, 4'hF, 2'b01, 0,  0,  0, 0, 0, 0);
        drive(0, 0, 0,  32'h0,        4'h0, 2'b11, 0,  19, 0, 0, 0, 0);
        // bypass on upper lanes, both ports same index
        drive(0, 1, 7,  32'hDEADBEEF, 4'hC, 2'b11, 7,  7,
              32'hDEAD0000, 32'hDEAD0000, 32'h0, 32'h0);
        drive(0, 0, 0,  32'h0,        4'h0, 2'b11, 7,  7,
              32'hDEAD0000, 32'hDEAD0000, 32'hDEAD0000, 32'hDEAD0000);
        // hold / valid
        drive(0, 1, 3,  32'h00000005, 4'hF, 2'b00, 0,  0,  0, 0, 0, 0);
        drive(0, 0, 0,  32'h0,        4'h0, 2'b01, 3,  0,  32'h5, 0, 32'h5, 0);
        drive(0, 0, 0,  32'h0,        4'h0, 2'b00, 7,  5,  0, 0, 0, 0);
        drive(0, 0, 0,  32'h0,        4'h0, 2'b00, 0,  19, 0, 0, 0, 0);
        // out-of-range write/read, no bypass on suppressed write
        drive(0, 1, 25, 32'hFFFFFFFF, 4'hF, 2'b11, 25, 5,
              0, 32'h11BB33DD, 0, 32'h11BB33DD);
        drive(0, 0, 0,  32'h0,        4'h0, 2'b11, 25, 19, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 32'h0, 4'h0, 2'b11, 5'(2*i), 5'(2*i+1),
                  final_reg(2*i), final_reg(2*i+1), final_reg(2*i), final_reg(2*i+1));
        end
        // wbe=0 is a no-op even with bypass
        drive(0, 1, 3,  32'hFFFFFFFF, 4'h0, 2'b01, 3,  0,  32'h5, 0, 32'h5, 0);
        // top register, single lane 1
        drive(0, 1, 19, 32'hA5A5A5A5, 4'h2, 2'b10, 0,  19,
              0, 32'h0000A500, 0, 32'h0);
        drive(0, 0, 0,  32'h0,        4'h0, 2'b11, 19, 3,
              32'h0000A500, 32'h5, 32'h0000A500, 32'h5);
        drive(0, 0, 0,  32'h0,        4'h0, 2'b00, 0,  0,  0, 0, 0, 0);
        drive(0, 0, 0,  32'h0,        4'h0, 2'b00, 0,  0,  0, 0, 0, 0);
        @(negedge clk);
        #1;
        for (int idx = 0; idx < 4; idx++) begin
            n_cmp++;
            if (q_size(idx) != 0) begin
                n_bad++;
                $display("FAIL drain queue%0d: got %0d reads never returned expected 0", idx, q_size(idx));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
